// File: rtl/cursor_src_arbiter.sv
// Once-per-frame cursor owner selection between the mouse stream and a keypad source.
// Outputs are clamped to the visible area and held stable for the whole frame.
module cursor_src_arbiter #(
    parameter int W           = 12,
    parameter int H_MAX       = 799,
    parameter int V_MAX       = 599,
    parameter int HOLD_FRAMES = 60
) (
    input  logic         pclk,
    input  logic         rst,
    input  logic         vs_in,
    input  logic [W-1:0] m_xpos,
    input  logic [W-1:0] m_ypos,
    input  logic         m_left,
    input  logic         k_valid,
    input  logic [W-1:0] k_xpos,
    input  logic [W-1:0] k_ypos,
    input  logic         k_left,
    output logic [W-1:0] xpos_out,
    output logic [W-1:0] ypos_out,
    output logic         left_out,
    output logic         left_click,
    output logic         frame_upd,
    output logic [1:0]   owner
);

    localparam int CW = $clog2(HOLD_FRAMES + 1);
    localparam logic [W-1:0]  H_LIM    = W'(H_MAX);
    localparam logic [W-1:0]  V_LIM    = W'(V_MAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_MOUSE = 2'b01,
        ST_KBD   = 2'b10
    } state_t;

    function automatic logic [W-1:0] clamp(input logic [W-1:0] v, input logic [W-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    state_t        state_r, state_nx_s;
    logic [CW-1:0] idle_cnt_r, cnt_nx_s;
    logic          vs_d_r;
    logic [W-1:0]  m_prev_x_r, m_prev_y_r;
    logic          m_act_r, k_act_r;
    logic [W-1:0]  k_x_r, k_y_r;
    logic          k_left_r;
    logic [W-1:0]  xpos_r, ypos_r, x_nx_s, y_nx_s;
    logic          left_r, left_nx_s, click_r, upd_r;
    logic          tick_s, m_now_s, a_m_s, a_k_s;

    assign tick_s  = vs_in & ~vs_d_r;
    assign m_now_s = (m_xpos != m_prev_x_r) | (m_ypos != m_prev_y_r) | m_left;
    assign a_m_s   = m_act_r | m_now_s;
    assign a_k_s   = k_act_r | k_valid;

    // Activity tracking: tick clears the per-frame flags, the tick cycle itself is seen through a_m_s/a_k_s.
    always_ff @(posedge pclk) begin
        if (rst) begin
            vs_d_r     <= 1'b0;
            m_prev_x_r <= '0;
            m_prev_y_r <= '0;
            m_act_r    <= 1'b0;
            k_act_r    <= 1'b0;
            k_x_r      <= '0;
            k_y_r      <= '0;
            k_left_r   <= 1'b0;
        end else begin
            vs_d_r     <= vs_in;
            m_prev_x_r <= m_xpos;
            m_prev_y_r <= m_ypos;
            m_act_r    <= tick_s ? 1'b0 : (m_act_r | m_now_s);
            k_act_r    <= tick_s ? 1'b0 : (k_act_r | k_valid);
            if (k_valid) begin
                k_x_r    <= k_xpos;
                k_y_r    <= k_ypos;
                k_left_r <= k_left;
            end
        end
    end

    // Ownership decision, only taken at the frame tick; the current owner is sticky on a tie.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = idle_cnt_r;
        if (tick_s) begin
            case (state_r)
                ST_IDLE: begin
                    cnt_nx_s = '0;
                    if (a_m_s) begin
                        state_nx_s = ST_MOUSE;
                    end else if (a_k_s) begin
                        state_nx_s = ST_KBD;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_MOUSE: begin
                    if (a_m_s) begin
                        cnt_nx_s = '0;
                    end else if (a_k_s) begin
                        state_nx_s = ST_KBD;
                        cnt_nx_s   = '0;
                    end else if (idle_cnt_r == CNT_LAST) begin
                        state_nx_s = ST_IDLE;
                        cnt_nx_s   = '0;
                    end else begin
                        cnt_nx_s = idle_cnt_r + CW'(1);
                    end
                end
                ST_KBD: begin
                    if (a_k_s) begin
                        cnt_nx_s = '0;
                    end else if (a_m_s) begin
                        state_nx_s = ST_MOUSE;
                        cnt_nx_s   = '0;
                    end else if (idle_cnt_r == CNT_LAST) begin
                        state_nx_s = ST_IDLE;
                        cnt_nx_s   = '0;
                    end else begin
                        cnt_nx_s = idle_cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                    cnt_nx_s   = '0;
                end
            endcase
        end else begin
            state_nx_s = state_r;
            cnt_nx_s   = idle_cnt_r;
        end
    end

    // Output selection for the owner chosen at this tick; keypad data in the tick cycle bypasses the shadow.
    always_comb begin
        x_nx_s    = xpos_r;
        y_nx_s    = ypos_r;
        left_nx_s = 1'b0;
        case (state_nx_s)
            ST_MOUSE: begin
                x_nx_s    = clamp(m_xpos, H_LIM);
                y_nx_s    = clamp(m_ypos, V_LIM);
                left_nx_s = m_left;
            end
            ST_KBD: begin
                x_nx_s    = clamp(k_valid ? k_xpos : k_x_r, H_LIM);
                y_nx_s    = clamp(k_valid ? k_ypos : k_y_r, V_LIM);
                left_nx_s = k_valid ? k_left : k_left_r;
            end
            default: begin
                x_nx_s    = xpos_r;
                y_nx_s    = ypos_r;
                left_nx_s = 1'b0;
            end
        endcase
    end

    // State and output registers; outputs change only on the tick edge.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            idle_cnt_r <= '0;
            xpos_r     <= '0;
            ypos_r     <= '0;
            left_r     <= 1'b0;
            click_r    <= 1'b0;
            upd_r      <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            idle_cnt_r <= cnt_nx_s;
            upd_r      <= tick_s;
            click_r    <= tick_s & left_nx_s & ~left_r;
            if (tick_s) begin
                xpos_r <= x_nx_s;
                ypos_r <= y_nx_s;
                left_r <= left_nx_s;
            end
        end
    end

    assign xpos_out   = xpos_r;
    assign ypos_out   = ypos_r;
    assign left_out   = left_r;
    assign left_click = click_r;
    assign frame_upd  = upd_r;
    assign owner      = state_r;

endmodule

// File: tb/tb_cursor_src_arbiter.sv
// Directed bench for cursor_src_arbiter with HOLD_FRAMES=3; expected values are hand-computed.
module tb_cursor_src_arbiter;

    localparam int W = 12;

    logic         pclk = 1'b0;
    logic         rst;
    logic         vs_in;
    logic [W-1:0] m_xpos, m_ypos;
    logic         m_left;
    logic         k_valid;
    logic [W-1:0] k_xpos, k_ypos;
    logic         k_left;
    logic [W-1:0] xpos_out, ypos_out;
    logic         left_out, left_click, frame_upd;
    logic [1:0]   owner;

    int n_checks = 0;
    int n_fail   = 0;

    cursor_src_arbiter #(
        .W(W), .H_MAX(799), .V_MAX(599), .HOLD_FRAMES(3)
    ) dut (
        .pclk(pclk), .rst(rst), .vs_in(vs_in),
        .m_xpos(m_xpos), .m_ypos(m_ypos), .m_left(m_left),
        .k_valid(k_valid), .k_xpos(k_xpos), .k_ypos(k_ypos), .k_left(k_left),
        .xpos_out(xpos_out), .ypos_out(ypos_out), .left_out(left_out),
        .left_click(left_click), .frame_upd(frame_upd), .owner(owner)
    );

    always #5 pclk = ~pclk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    // One rising vs_in edge seen by the DUT on the next clock; outputs sampled #1 after it.
    task automatic tick_edge();
        vs_in = 1'b1;
        cyc(1);
        vs_in = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int x, input int y, input int l,
                              input int c, input int u, input int o);
        check({tag, ".xpos"},  32'(xpos_out),   x);
        check({tag, ".ypos"},  32'(ypos_out),   y);
        check({tag, ".left"},  32'(left_out),   l);
        check({tag, ".click"}, 32'(left_click), c);
        check({tag, ".upd"},   32'(frame_upd),  u);
        check({tag, ".owner"}, 32'(owner),      o);
    endtask

    task automatic kbd(input int x, input int y, input logic l);
        k_valid = 1'b1;
        k_xpos  = W'(x);
        k_ypos  = W'(y);
        k_left  = l;
    endtask

    initial begin
        rst = 1'b1; vs_in = 1'b0;
        m_xpos = '0; m_ypos = '0; m_left = 1'b0;
        k_valid = 1'b0; k_xpos = '0; k_ypos = '0; k_left = 1'b0;
        cyc(2);
        expect_out("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // 1: first mouse position after reset takes ownership
        m_xpos = 12'd100; m_ypos = 12'd50;
        cyc(3);
        tick_edge();
        expect_out("t1_tick", 100, 50, 0, 0, 1, 1);
        cyc(1);
        expect_out("t1_after", 100, 50, 0, 0, 0, 1);

        // 2: keypad takes over from a static mouse, then stays owner on a tie
        kbd(300, 200, 1'b0); cyc(1); k_valid = 1'b0;
        cyc(2);
        tick_edge();
        expect_out("t2_switch", 300, 200, 0, 0, 1, 2);
        m_xpos = 12'd120;
        kbd(310, 210, 1'b0); cyc(1); k_valid = 1'b0;
        cyc(2);
        tick_edge();
        expect_out("t2_sticky", 310, 210, 0, 0, 1, 2);

        // keypad owner idles out after three quiet frames
        cyc(3); tick_edge();
        expect_out("kbd_hold1", 310, 210, 0, 0, 1, 2);
        cyc(3); tick_edge();
        expect_out("kbd_hold2", 310, 210, 0, 0, 1, 2);
        cyc(3); tick_edge();
        expect_out("kbd_release", 310, 210, 0, 0, 1, 0);

        // 3: clamp and click from IDLE, no click on repeat, tick-cycle bypass of the shadow
        kbd(1023, 700, 1'b1); cyc(1); k_valid = 1'b0;
        cyc(2);
        tick_edge();
        expect_out("t3_clamp", 799, 599, 1, 1, 1, 2);
        cyc(1);
        expect_out("t3_pulse_end", 799, 599, 1, 0, 0, 2);
        kbd(1023, 700, 1'b1); cyc(1); k_valid = 1'b0;
        cyc(2);
        tick_edge();
        expect_out("t3_no_click", 799, 599, 1, 0, 1, 2);
        cyc(3);
        kbd(640, 20, 1'b1);
        tick_edge();
        k_valid = 1'b0;
        expect_out("t3_direct", 640, 20, 1, 0, 1, 2);

        // 4: mouse takes over, then releases at the third quiet tick
        m_xpos = 12'd200; m_ypos = 12'd100; m_left = 1'b1;
        cyc(3);
        tick_edge();
        m_left = 1'b0;
        expect_out("t4_take", 200, 100, 1, 0, 1, 1);
        cyc(3); tick_edge();
        expect_out("t4_idle1", 200, 100, 0, 0, 1, 1);
        cyc(3); tick_edge();
        expect_out("t4_idle2", 200, 100, 0, 0, 1, 1);
        cyc(3); tick_edge();
        expect_out("t4_release", 200, 100, 0, 0, 1, 0);

        // 5: simultaneous first request in the tick cycle, mouse wins
        cyc(3);
        m_xpos = 12'd400; m_ypos = 12'd300; m_left = 1'b1;
        kbd(500, 400, 1'b0);
        tick_edge();
        k_valid = 1'b0; m_left = 1'b0;
        expect_out("t5_tie", 400, 300, 1, 1, 1, 1);

        // 6: reset mid-frame discards pending keypad activity
        m_xpos = '0; m_ypos = '0;
        cyc(3);
        kbd(600, 500, 1'b1); cyc(1); k_valid = 1'b0;
        cyc(1);
        rst = 1'b1;
        cyc(1);
        expect_out("t6_reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        cyc(3);
        tick_edge();
        expect_out("t6_quiet", 0, 0, 0, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
